pc_ctrl_unit: RTL

Parametrised program-counter unit for the MIPS core, replacing the bare per-bit PC register. It holds the PC and selects the next PC from sequential, branch, jump, jump-register, exception and exception-return sources. It supports stall, halt/resume, and a small exception state machine with EPC capture and double-fault detection. It sits between the control/branch logic and instruction memory; `pc` drives the instruction-memory address directly.

---
 rtl/pc_ctrl_if.sv | 37 +++
 rtl/pc_ctrl_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pc_ctrl_if.sv
// Control/branch side to PC unit bundle: redirect requests in, PC and
// exception status out.
interface pc_ctrl_if #(
  parameter int WIDTH = 32
);
  logic              stall;
  logic              branch_taken;
  logic [15:0]       branch_imm;
  logic              jump;
  logic [25:0]       jump_idx;
  logic              jr;
  logic [WIDTH-1:0]  jr_addr;
  logic              exc;
  logic              eret;
  logic              halt;
  logic              resume;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  pc_inc;
  logic [WIDTH-1:0]  epc;
  logic [1:0]        cause;
  logic              in_handler;
  logic              halted;
  logic              double_fault;
  logic [1:0]        dbg_state;

  modport master (
    output stall, branch_taken, branch_imm, jump, jump_idx, jr, jr_addr,
           exc, eret, halt, resume,
    input  pc, pc_inc, epc, cause, in_handler, halted, double_fault, dbg_state
  );

  modport slave (
    input  stall, branch_taken, branch_imm, jump, jump_idx, jr, jr_addr,
           exc, eret, halt, resume,
    output pc, pc_inc, epc, cause, in_handler, halted, double_fault, dbg_state
  );
endinterface

// File: rtl/pc_ctrl_unit.sv
// Program-counter unit: next-PC selection, stall/halt, and a small
// exception FSM with EPC capture and sticky double-fault detection.
module pc_ctrl_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          INC          = 4
) (
  input  logic        clk,
  input  logic        reset,
  pc_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic             df_q, df_d;

  logic [WIDTH-1:0] seq, br, jmp, br_off;
  logic             jr_misaligned, fault;

  assign seq    = pc_q + INC_W;
  assign br_off = {{(WIDTH-16){bus.branch_imm[15]}}, bus.branch_imm} << 2;
  assign br     = seq + br_off;

  // J-type keeps the upper region bits of the sequential PC; at WIDTH 28
  // there are none left.
  generate
    if (WIDTH > 28) begin : g_jmp_hi
      assign jmp = {seq[WIDTH-1:28], bus.jump_idx, 2'b00};
    end else begin : g_jmp_lo
      assign jmp = {bus.jump_idx, 2'b00};
    end
  endgenerate

  assign jr_misaligned = bus.jr & ~bus.stall & (bus.jr_addr[1:0] != 2'b00);
  assign fault         = bus.exc | jr_misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RST_PC;
      epc_q   <= '0;
      cause_q <= 2'b00;
      df_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      df_q    <= df_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    df_d    = df_q;
    case (state_q)
      RUN, HANDLER: begin
        // Fault outranks stall so an exception is never lost while stalled.
        if (fault) begin
          if (state_q == RUN) begin
            epc_d   = pc_q;
            cause_d = jr_misaligned ? 2'b10 : 2'b01;
            pc_d    = EXC_PC;
            state_d = HANDLER;
          end else begin
            df_d    = 1'b1;
            state_d = HALT;
          end
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.halt) begin
          pc_d    = seq;
          state_d = HALT;
        end else if (bus.eret && state_q == HANDLER) begin
          pc_d    = epc_q;
          cause_d = 2'b00;
          state_d = RUN;
        end else if (bus.jr) begin
          pc_d = bus.jr_addr;
        end else if (bus.jump) begin
          pc_d = jmp;
        end else if (bus.branch_taken) begin
          pc_d = br;
        end else begin
          pc_d = seq;
        end
      end
      HALT: begin
        if (bus.resume && !df_q) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.pc           = pc_q;
  assign bus.pc_inc       = seq;
  assign bus.epc          = epc_q;
  assign bus.cause        = cause_q;
  assign bus.in_handler   = (state_q == HANDLER);
  assign bus.halted       = (state_q == HALT);
  assign bus.double_fault = df_q;
  assign bus.dbg_state    = state_q;

endmodule
